// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I fetch/PC stage.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // JALR clears bit 0 of the computed target.
  localparam logic [XLEN-1:0] ALIGN_MASK_JALR = 32'hFFFF_FFFE;

  typedef enum logic {
    RUN,
    HALTED
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JAL,
    SEL_JALR
  } pc_sel_e;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC target arithmetic, priority select and misalign detect.
module next_pc_select
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  output logic [XLEN-1:0] target,
  output logic            taken,
  output logic            misaligned
);

  pc_sel_e         sel;
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;

  assign seq      = pc + 32'd4;
  assign br_tgt   = pc + imm;
  assign jalr_tgt = (rs1 + imm) & ALIGN_MASK_JALR;

  // Priority: jalr > jump > branch > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (jalr)              sel = SEL_JALR;
    else if (jump)         sel = SEL_JAL;
    else if (branch_taken) sel = SEL_BR;
  end

  // Target mux plus redirect/misalign flags; seq is always word aligned.
  always_comb begin
    target = seq;
    case (sel)
      SEL_BR,
      SEL_JAL:  target = br_tgt;
      SEL_JALR: target = jalr_tgt;
      default:  target = seq;
    endcase
    taken      = (sel != SEL_SEQ);
    misaligned = taken & target[1];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with RUN/HALTED control, misaligned-target trap and redirect counter.
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_target,
  output logic            halted,
  output logic [XLEN-1:0] redirect_count
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [XLEN-1:0] trap_target_q, trap_target_d;
  logic [XLEN-1:0] count_q, count_d;

  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;

  next_pc_select u_next_pc_select (
    .pc           (pc_q),
    .imm          (imm),
    .rs1          (rs1),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .target       (target),
    .taken        (taken),
    .misaligned   (misaligned)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      trap_q        <= 1'b0;
      trap_pc_q     <= '0;
      trap_target_q <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_q        <= trap_d;
      trap_pc_q     <= trap_pc_d;
      trap_target_q <= trap_target_d;
      count_q       <= count_d;
    end
  end

  // Next-state logic: halt beats stall, stall beats redirect; HALTED freezes everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    trap_d        = 1'b0;
    trap_pc_d     = trap_pc_q;
    trap_target_d = trap_target_q;
    count_d       = count_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (!stall) begin
          if (misaligned) begin
            pc_d          = TRAP_VECTOR;
            trap_d        = 1'b1;
            trap_pc_d     = pc_q;
            trap_target_d = target;
          end else begin
            pc_d = target;
            if (taken) count_d = count_q + 32'd1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign trap           = trap_q;
  assign trap_pc        = trap_pc_q;
  assign trap_target    = trap_target_q;
  assign halted         = (state_q == HALTED);
  assign redirect_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus vs. a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_target;
  logic        halted;
  logic [31:0] redirect_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_trap;
  logic [31:0] m_tpc;
  logic [31:0] m_ttgt;
  logic        m_halted;
  logic [31:0] m_cnt;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .halt_req       (halt_req),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .jalr           (jalr),
    .imm            (imm),
    .rs1            (rs1),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .trap           (trap),
    .trap_pc        (trap_pc),
    .trap_target    (trap_target),
    .halted         (halted),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural rules applied to the model on one clock edge.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        tk;
    if (rst) begin
      m_pc = RV; m_trap = 0; m_tpc = 0; m_ttgt = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
      m_trap = 0;
    end else if (halt_req) begin
      m_halted = 1; m_trap = 0;
    end else if (stall) begin
      m_trap = 0;
    end else begin
      tk = jalr | jump | branch_taken;
      if (jalr)                tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      else if (jump | branch_taken) tgt = m_pc + imm;
      else                     tgt = m_pc + 32'd4;
      if (tk && tgt[1]) begin
        m_tpc = m_pc; m_ttgt = tgt; m_pc = TV; m_trap = 1;
      end else begin
        m_pc = tgt; m_trap = 0;
        if (tk) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic compare_model();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("trap", 32'(trap), 32'(m_trap));
    check("trap_pc", trap_pc, m_tpc);
    check("trap_target", trap_target, m_ttgt);
    check("halted", 32'(halted), 32'(m_halted));
    check("redirect_count", redirect_count, m_cnt);
  endtask

  // Drive one cycle of inputs, clock it, then check DUT against the model.
  task automatic step(input logic r, input logic s, input logic h, input logic b,
                      input logic j, input logic jr, input logic [31:0] im,
                      input logic [31:0] r1);
    rst = r; stall = s; halt_req = h; branch_taken = b; jump = j; jalr = jr;
    imm = im; rs1 = r1;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] off);
    step(0, 0, 0, 0, 1, 0, off, 32'h0);
  endtask

  initial begin
    rst = 1; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jalr = 0;
    imm = 0; rs1 = 0;
    m_pc = 0; m_trap = 0; m_tpc = 0; m_ttgt = 0; m_halted = 0; m_cnt = 0;
    @(negedge clk);

    // 1: reset and sequential fetch
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_cnt", redirect_count, 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    idle(); check("seq1", pc, 32'h4);
    idle(); check("seq2", pc, 32'h8);
    idle(); check("seq3", pc, 32'hC);

    // 2: branch back, first under stall then free
    do_reset();
    jump_to(32'h10);
    check("jal_pc", pc, 32'h10);
    step(0, 1, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
    check("stall_pc", pc, 32'h10);
    check("stall_cnt", redirect_count, 32'h1);
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
    check("br_pc", pc, 32'h08);
    check("br_cnt", redirect_count, 32'h2);

    // 3: jalr wins over jump/branch, target 0x1002 misaligned
    do_reset();
    jump_to(32'h20);
    step(0, 0, 0, 1, 1, 1, 32'h2, 32'h1001);
    check("jalr_pc", pc, TV);
    check("jalr_trap", 32'(trap), 32'h1);
    check("jalr_ttgt", trap_target, 32'h1002);
    check("jalr_tpc", trap_pc, 32'h20);

    // 4: JAL misaligned trap, one-cycle pulse, then back-to-back traps
    do_reset();
    jump_to(32'h40);
    jump_to(32'h6);
    check("mis_pc", pc, 32'h100);
    check("mis_trap", 32'(trap), 32'h1);
    check("mis_tpc", trap_pc, 32'h40);
    check("mis_ttgt", trap_target, 32'h46);
    check("mis_cnt", redirect_count, 32'h1);
    idle();
    check("pulse_end", 32'(trap), 32'h0);
    check("tpc_hold", trap_pc, 32'h40);
    jump_to(32'h2);
    check("trap_b2b_a", 32'(trap), 32'h1);
    jump_to(32'h2);
    check("trap_b2b_b", 32'(trap), 32'h1);
    check("trapvec_plus2", trap_target, 32'h102);

    // 5: wraparound of seq and branch
    do_reset();
    jump_to(32'hFFFF_FFFC);
    idle();
    check("wrap_seq", pc, 32'h0);
    jump_to(32'h8);
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
    check("wrap_br", pc, 32'h0);

    // 6: halt under stall, frozen despite controls, reset exits
    do_reset();
    jump_to(32'h30);
    step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("halt_on", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++)
      step(0, 1'(i & 1), 1'($urandom_range(0, 1)), 1'(i & 1), 1'(~i & 1), 1'(i % 3 == 0),
           32'h4 << (i % 4), 32'h0);
    check("halt_pc", pc, 32'h30);
    check("halt_cnt", redirect_count, 32'h1);
    do_reset();
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_h", 32'(halted), 32'h0);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] im;
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'($signed($urandom_range(0, 63)) - 32);
        2: im = {$urandom_range(0, 255), 2'b00};
        default: im = 32'(2 * $urandom_range(0, 40));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           im, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage that consumes `branch_taken` from the branch comparator, plus decoder jump controls, and produces the fetch PC for the single-cycle RV32I core.
- Computes the next PC: sequential, branch, JAL or JALR.
- Detects misaligned control-transfer targets (no C extension) and redirects to a trap vector.
- Supports fetch stall and a sticky halt.
- Keeps a wrapping count of taken redirects for debug.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  fetch not ready; hold all state
- halt_req  in  1  ECALL/EBREAK from decoder; enter HALTED
- branch_taken  in  1  from branch comparator, already gated by branch
- jump  in  1  JAL
- jalr  in  1  JALR
- imm  in  32  sign-extended immediate
- rs1  in  32  register rs1 value
- pc  out  32  current fetch PC (registered)
- pc_plus4  out  32  pc+4 (combinational), link value for rd
- trap  out  1  one-cycle pulse, high in the first cycle pc==TRAP_VECTOR
- trap_pc  out  32  PC of the faulting instruction (registered)
- trap_target  out  32  offending target address (registered)
- halted  out  1  high while in HALTED
- redirect_count  out  32  number of taken non-trapping redirects

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled on the rising edge of clk.
- Reset values:
  - pc=RESET_VECTOR, state=RUN.
  - trap=0, trap_pc=0, trap_target=0, halted=0, redirect_count=0.
- Target computation, all mod 2^32:
  - seq = pc+4; 0xFFFF_FFFC wraps to 0.
  - br_tgt = pc+imm, used by branch and JAL.
  - jalr_tgt = (rs1+imm) & ~32'h1.
- Select priority: jalr > jump > branch_taken > seq. Simultaneous controls resolve by this priority; no error is raised.
- Misaligned: a redirect is taken and target[1]==1. seq is never misaligned.
- FSM states: RUN, HALTED.
- RUN, per-edge priority:
  - rst: reset values.
  - halt_req: go to HALTED. Takes effect even if stall=1. pc holds (points at the halting instruction).
  - stall: hold pc, trap_pc, trap_target and redirect_count. trap=0.
  - misaligned redirect:
    - pc<=TRAP_VECTOR, trap<=1, trap_pc<=pc, trap_target<=selected target.
    - redirect_count unchanged.
  - otherwise: pc<=selected target, trap<=0. redirect_count+=1 (wraps) when a redirect is taken.
- HALTED:
  - All inputs except rst are ignored. pc and counters are frozen, halted=1, trap=0.
  - Only rst exits HALTED.
- trap is a single-cycle pulse; a back-to-back trap re-pulses it.
- Rules for trap_pc / trap_target:
  - They hold until the next trap or reset.
  - A trap whose selected target is TRAP_VECTOR+2 still traps.
- pc_plus4 is combinational from the registered pc. It is valid in HALTED and during stall.
- Reset mid-stall or in HALTED: reset wins on the same edge.

Decomposition:
- Shared package (core_pkg) holds:
  - XLEN=32.
  - pc_state_e {RUN, HALTED}.
  - pc_sel_e {SEL_SEQ, SEL_BR, SEL_JAL, SEL_JALR}.
  - ALIGN_MASK_JALR constant.
- One sub-module, next_pc_select: purely combinational.
  - Does target arithmetic, priority select and misalign detect.
  - Outputs next target, a taken flag and a misaligned flag.
- The top level holds the pc register, FSM, trap registers and counter.

Test Plan:
1. Reset, no controls, 3 cycles -> pc 0x0, 0x4, 0x8, 0xC. redirect_count=0, trap=0.
2. pc=0x10, branch_taken=1, imm=-8 -> next pc 0x08, redirect_count=1. With stall=1 on the same edge -> pc stays 0x10, count unchanged.
3. pc=0x20, jalr=1, rs1=0x1001, imm=0x2, with jump=1 and branch_taken=1 also set -> jalr wins, pc=0x1002 (bit0 cleared, bit1 set) -> misaligned trap.
4. Misaligned trap: pc=0x40, jump=1, imm=0x6 -> pc=0x100, trap=1 for exactly one cycle, trap_pc=0x40, trap_target=0x46, redirect_count unchanged.
5. pc=0xFFFF_FFFC, no controls -> pc=0x0000_0000. Separately, pc=0x8, branch_taken=1, imm=0xFFFF_FFF8 -> pc=0x0.
6. Halt: halt_req=1 with stall=1 at pc=0x30 -> halted=1, pc=0x30 frozen for 10 cycles despite jump/branch toggling. rst=1 -> pc=0x0, halted=0 on the following cycle.
